// File: rtl/assertion_monitor.sv
// -----------------------------------------------------------------------------
// assertion_monitor
//
// Checker stage placed downstream of the counter block. After reset or clear
// it ignores `valid` for SETTLE clock edges, then treats every edge with
// valid==0 as a violation. It records:
//   - a sticky failure flag,
//   - the cycle number and `count` value of the first violation,
//   - a saturating total of violations.
// Test harnesses and formal scripts read these outputs as a pass/fail summary.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   valid        in   upstream assertion result (0 = violation)
//   count        in   upstream count value, captured at the first violation
//   clear        in   synchronous clear; restarts monitoring, wins over valid==0
//   armed        out  1 while violations are being checked
//   fail         out  sticky flag, set by the first checked violation
//   fail_count   out  number of checked violations, saturating
//   first_cycle  out  cycle counter value at the first violation
//   first_count  out  `count` value at the first violation
//   state_dbg    out  current FSM state (0 SETTLE, 1 ARMED, 2 FAILED)
//
// Handshake: there is no handshake. `valid` is sampled on every rising edge
// while armed, and all outputs are registered (latency 1 from the edge).
// -----------------------------------------------------------------------------
module assertion_monitor #(
   parameter int CNT_W  = 4,
   parameter int CYC_W  = 16,
   parameter int ERR_W  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [CNT_W-1:0] count,
   input  logic             clear,
   output logic             armed,
   output logic             fail,
   output logic [ERR_W-1:0] fail_count,
   output logic [CYC_W-1:0] first_cycle,
   output logic [CNT_W-1:0] first_count,
   output logic [1:0]       state_dbg
);

   // Settle counter needs to hold SETTLE itself; keep at least one bit so the
   // SETTLE=0 build still has a legal (unused) register.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_ARMED  = 2'd1,
      ST_FAILED = 2'd2
   } state_t;

   // With no settle window the monitor comes out of reset already armed.
   localparam state_t ST_INIT = (SETTLE == 0) ? ST_ARMED : ST_SETTLE;

   state_t           state_q,       state_d;
   logic [SW-1:0]    settle_cnt_q,  settle_cnt_d;
   logic [CYC_W-1:0] cycle_cnt_q,   cycle_cnt_d;
   logic             fail_q,        fail_d;
   logic [ERR_W-1:0] fail_count_q,  fail_count_d;
   logic [CYC_W-1:0] first_cycle_q, first_cycle_d;
   logic [CNT_W-1:0] first_count_q, first_count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_INIT;
         settle_cnt_q  <= SETTLE_INIT;
         cycle_cnt_q   <= '0;
         fail_q        <= 1'b0;
         fail_count_q  <= '0;
         first_cycle_q <= '0;
         first_count_q <= '0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         cycle_cnt_q   <= cycle_cnt_d;
         fail_q        <= fail_d;
         fail_count_q  <= fail_count_d;
         first_cycle_q <= first_cycle_d;
         first_count_q <= first_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      fail_d        = fail_q;
      fail_count_d  = fail_count_q;
      first_cycle_d = first_cycle_q;
      first_count_d = first_count_q;

      // Free-running edge counter, saturating so a long run never aliases
      // back onto small timestamps.
      cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CYC_W'(1);

      case (state_q)
         ST_SETTLE: begin
            settle_cnt_d = settle_cnt_q - SW'(1);
            if (settle_cnt_q == SW'(1)) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!valid) begin
               fail_d        = 1'b1;
               first_cycle_d = cycle_cnt_q;  // pre-increment value
               first_count_d = count;
               fail_count_d  = ERR_W'(1);
               state_d       = ST_FAILED;
            end
         end
         ST_FAILED: begin
            if (!valid && (fail_count_q != '1)) begin
               fail_count_d = fail_count_q + ERR_W'(1);
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Clear overrides everything evaluated above, including a violation
      // sampled on the same edge.
      if (clear) begin
         state_d       = ST_INIT;
         settle_cnt_d  = SETTLE_INIT;
         cycle_cnt_d   = '0;
         fail_d        = 1'b0;
         fail_count_d  = '0;
         first_cycle_d = '0;
         first_count_d = '0;
      end
   end

   assign armed       = (state_q != ST_SETTLE);
   assign fail        = fail_q;
   assign fail_count  = fail_count_q;
   assign first_cycle = first_cycle_q;
   assign first_count = first_count_q;
   assign state_dbg   = state_q;

   // Simulation-only: an unknown `valid` while checking is a bench error.
   a_valid_known : assert property (@(posedge clk) disable iff (rst)
      (state_q != ST_SETTLE) |-> !$isunknown(valid));

endmodule

// File: tb/tb_assertion_monitor.sv
// -----------------------------------------------------------------------------
// tb_assertion_monitor
//
// Four monitor instances share one stimulus stream:
//   u0 default parameters, u1 ERR_W=2, u2 CYC_W=3, u3 SETTLE=0.
// A reference model tracks, per instance, the number of edges since the last
// reset/clear and the list of checked violations, and derives every expected
// output from those quantities.
// -----------------------------------------------------------------------------
module tb_assertion_monitor;

   localparam int N = 4;
   localparam int S_P [N] = '{2, 2, 2, 0};
   localparam int C_P [N] = '{16, 16, 3, 16};
   localparam int E_P [N] = '{8, 2, 8, 8};

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   = 1'b1;
   logic       valid = 1'b1;
   logic [3:0] count = 4'd0;
   logic       clear = 1'b0;

   // ---------------------------------------------------------------- DUTs
   logic        armed0, fail0, armed1, fail1, armed2, fail2, armed3, fail3;
   logic [7:0]  fcnt0, fcnt2, fcnt3;
   logic [1:0]  fcnt1;
   logic [15:0] fcyc0, fcyc1, fcyc3;
   logic [2:0]  fcyc2;
   logic [3:0]  fval0, fval1, fval2, fval3;
   logic [1:0]  st0, st1, st2, st3;

   assertion_monitor u0 (.clk(clk), .rst(rst), .valid(valid), .count(count), .clear(clear),
      .armed(armed0), .fail(fail0), .fail_count(fcnt0), .first_cycle(fcyc0),
      .first_count(fval0), .state_dbg(st0));
   assertion_monitor #(.ERR_W(2)) u1 (.clk(clk), .rst(rst), .valid(valid), .count(count),
      .clear(clear), .armed(armed1), .fail(fail1), .fail_count(fcnt1), .first_cycle(fcyc1),
      .first_count(fval1), .state_dbg(st1));
   assertion_monitor #(.CYC_W(3)) u2 (.clk(clk), .rst(rst), .valid(valid), .count(count),
      .clear(clear), .armed(armed2), .fail(fail2), .fail_count(fcnt2), .first_cycle(fcyc2),
      .first_count(fval2), .state_dbg(st2));
   assertion_monitor #(.SETTLE(0)) u3 (.clk(clk), .rst(rst), .valid(valid), .count(count),
      .clear(clear), .armed(armed3), .fail(fail3), .fail_count(fcnt3), .first_cycle(fcyc3),
      .first_count(fval3), .state_dbg(st3));

   logic [31:0] o_armed [N];
   logic [31:0] o_fail  [N];
   logic [31:0] o_fcnt  [N];
   logic [31:0] o_fcyc  [N];
   logic [31:0] o_fval  [N];
   logic [31:0] o_st    [N];

   assign o_armed[0] = 32'(armed0); assign o_armed[1] = 32'(armed1);
   assign o_armed[2] = 32'(armed2); assign o_armed[3] = 32'(armed3);
   assign o_fail[0]  = 32'(fail0);  assign o_fail[1]  = 32'(fail1);
   assign o_fail[2]  = 32'(fail2);  assign o_fail[3]  = 32'(fail3);
   assign o_fcnt[0]  = 32'(fcnt0);  assign o_fcnt[1]  = 32'(fcnt1);
   assign o_fcnt[2]  = 32'(fcnt2);  assign o_fcnt[3]  = 32'(fcnt3);
   assign o_fcyc[0]  = 32'(fcyc0);  assign o_fcyc[1]  = 32'(fcyc1);
   assign o_fcyc[2]  = 32'(fcyc2);  assign o_fcyc[3]  = 32'(fcyc3);
   assign o_fval[0]  = 32'(fval0);  assign o_fval[1]  = 32'(fval1);
   assign o_fval[2]  = 32'(fval2);  assign o_fval[3]  = 32'(fval3);
   assign o_st[0]    = 32'(st0);    assign o_st[1]    = 32'(st1);
   assign o_st[2]    = 32'(st2);    assign o_st[3]    = 32'(st3);

   // ---------------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // since[i]: edges since last reset/clear; viol_q[i]: counts captured at
   // each checked violation; first_cyc[i]: timestamp of the first one.
   int         since     [N];
   int         first_cyc [N];
   logic [3:0] viol_q    [N][$];

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         since[i]     = 0;
         first_cyc[i] = 0;
         viol_q[i].delete();
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         if (clear) begin
            since[i]     = 0;
            first_cyc[i] = 0;
            viol_q[i].delete();
         end else begin
            if (since[i] >= S_P[i] && !valid) begin
               if (viol_q[i].size() == 0) first_cyc[i] = sat(since[i], C_P[i]);
               viol_q[i].push_back(count);
            end
            since[i]++;
         end
      end
   endtask

   task automatic check_all();
      int nv;
      int exp_st;
      for (int i = 0; i < N; i++) begin
         nv     = viol_q[i].size();
         exp_st = (since[i] < S_P[i]) ? 0 : ((nv > 0) ? 2 : 1);
         check_val($sformatf("u%0d.armed", i), o_armed[i], 32'(since[i] >= S_P[i]));
         check_val($sformatf("u%0d.fail", i), o_fail[i], 32'(nv > 0));
         check_val($sformatf("u%0d.fail_count", i), o_fcnt[i], 32'(sat(nv, E_P[i])));
         check_val($sformatf("u%0d.first_cycle", i), o_fcyc[i], 32'(first_cyc[i]));
         check_val($sformatf("u%0d.first_count", i), o_fval[i],
                   (nv > 0) ? 32'(viol_q[i][0]) : 32'd0);
         check_val($sformatf("u%0d.state", i), o_st[i], 32'(exp_st));
      end
   endtask

   // ---------------------------------------------------------------- driver
   task automatic step(input logic v, input logic [3:0] c, input logic clr);
      valid = v;
      count = c;
      clear = clr;
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_all();
   endtask

   // Reset asserted between edges; outputs must drop before the next edge.
   task automatic pulse_rst();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_val("async_rst.fail", o_fail[0], 32'd0);
      check_all();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_all();
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      model_reset();
      #12;
      check_all();                              // reset state
      @(negedge clk);
      rst = 1'b0;

      // settle window: violations ignored for edges 1-2 on u0..u2
      step(1'b0, 4'd3, 1'b0);
      check_val("settle.armed_edge1", o_armed[0], 32'd0);
      step(1'b0, 4'd3, 1'b0);
      check_val("settle.armed_edge2", o_armed[0], 32'd1);
      check_val("settle.fail", o_fail[0], 32'd0);

      // clean until cycle_cnt==7, then one violation with count=5
      repeat (5) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      step(1'b0, 4'd5, 1'b0);
      check_val("capture.fail", o_fail[0], 32'd1);
      check_val("capture.first_cycle", o_fcyc[0], 32'd7);
      check_val("capture.first_count", o_fval[0], 32'd5);
      check_val("capture.fail_count", o_fcnt[0], 32'd1);

      // repeat violations
      repeat (3) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      check_val("repeat.fail_count", o_fcnt[0], 32'd4);
      check_val("repeat.first_cycle", o_fcyc[0], 32'd7);
      check_val("repeat.first_count", o_fval[0], 32'd5);
      repeat (3) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      check_val("sat.err_w2", o_fcnt[1], 32'd3);

      // clear wins over a same-edge violation
      step(1'b0, 4'd9, 1'b1);
      check_val("clear.fail", o_fail[0], 32'd0);
      check_val("clear.fail_count", o_fcnt[0], 32'd0);
      check_val("clear.armed", o_armed[0], 32'd0);
      repeat (2) step(1'b1, 4'd0, 1'b0);
      check_val("clear.rearmed", o_armed[0], 32'd1);

      // cycle counter saturation on CYC_W=3
      repeat (10) step(1'b1, 4'd1, 1'b0);
      step(1'b0, 4'd9, 1'b0);
      check_val("sat.cyc_w3", o_fcyc[2], 32'd7);
      check_val("cyc.first_cycle_u0", o_fcyc[0], 32'd12);

      // asynchronous reset while FAILED
      pulse_rst();

      // SETTLE=0: first edge after release is checked
      step(1'b0, 4'd6, 1'b0);
      check_val("settle0.fail", o_fail[3], 32'd1);
      check_val("settle0.first_cycle", o_fcyc[3], 32'd0);
      check_val("settle0.other_ignored", o_fail[0], 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_rst();
         end else begin
            step(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 39) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/assertion_monitor.md
Name: assertion_monitor

Overview:
Checker stage that sits directly downstream of the counter block and consumes its `valid` assertion output together with the observed `count` value. It ignores a settling window after reset, then flags any cycle in which `valid` is low. It latches a sticky failure flag, the cycle number and `count` value of the first violation, and a saturating total of violations. Test harnesses and formal scripts read these outputs as a single pass/fail summary.

Parameters:
- CNT_W, 4: width of the observed count bus.
- CYC_W, 16: width of the cycle counter and of the first-failure timestamp.
- ERR_W, 8: width of the violation counter.
- SETTLE, 2: number of clock edges after reset or clear during which violations are ignored (0 means armed immediately).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- valid, input, 1: assertion result from the upstream block; 0 means violation.
- count, input, CNT_W: upstream count value, captured at the first violation.
- clear, input, 1: synchronous clear; restarts monitoring.
- armed, output, 1: 1 when violations are being checked.
- fail, output, 1: sticky flag, set on the first checked violation.
- fail_count, output, ERR_W: number of checked violations, saturating.
- first_cycle, output, CYC_W: cycle_cnt value at the first violation.
- first_count, output, CNT_W: `count` value at the first violation.

Behaviour:
- One clock domain (`clk`). Reset `rst` is asynchronous and active-high.
- States:
  - SETTLE: ignoring violations.
  - ARMED: checking, no failure yet.
  - FAILED: checking, failure latched.
- Reset values:
  - State is SETTLE, or ARMED if SETTLE=0.
  - settle_cnt = SETTLE, cycle_cnt = 0.
  - fail = 0, fail_count = 0, first_cycle = 0, first_count = 0.
  - armed = (state != SETTLE).
- cycle_cnt:
  - Internal; increments on every edge that has no clear.
  - Saturates at all-ones and never wraps.
- SETTLE state:
  - Each edge decrements settle_cnt.
  - The edge on which settle_cnt==1 moves the state to ARMED.
  - `valid` is ignored in this state. The first sampled edge is therefore edge SETTLE+1, where cycle_cnt == SETTLE.
- ARMED state, edge with valid==0:
  - fail <= 1.
  - first_cycle <= cycle_cnt (the pre-increment value).
  - first_count <= count.
  - fail_count <= 1.
  - State moves to FAILED.
- FAILED state, edge with valid==0:
  - fail_count increments, saturating at 2^ERR_W-1.
  - first_* and fail hold their values.
- All outputs are registered; a violation becomes visible the cycle after the sampling edge (latency 1).
- `valid` is treated as 0/1 only. X/Z on `valid` while armed is a bench error and is flagged by a simulation-only check.
- clear (synchronous, edge with clear==1):
  - Has priority over a violation on the same edge; that violation is dropped.
  - Returns all state to reset values, including the SETTLE window.
- rst asserted mid-operation: immediate asynchronous return to reset values, regardless of state.
- No state leaves FAILED except via rst or clear.

Test Plan:
- Settle window:
  - Stimulus: SETTLE=2; release rst; hold valid=0 for edges 1–2; valid=1 afterwards.
  - Required: armed=1 after edge 2; fail=0 and fail_count=0 throughout.
- First capture:
  - Stimulus: valid=1 until cycle_cnt=7; valid=0 for one edge with count=4'd5.
  - Required: next cycle fail=1, first_cycle=7, first_count=5, fail_count=1.
- Repeat violations:
  - Stimulus: after the first failure, three more valid=0 edges with varied count.
  - Required: fail_count=4; first_cycle and first_count unchanged.
- Saturation:
  - Stimulus: ERR_W=2; six violations.
  - Required: fail_count sticks at 3.
  - Stimulus: CYC_W=3 with 12 clean edges.
  - Required: a violation then records first_cycle=7.
- Clear vs violation:
  - Stimulus: clear=1 and valid=0 on the same edge.
  - Required: fail=0, fail_count=0, armed=0, then re-armed two edges later.
- Reset mid-failure:
  - Stimulus: assert rst asynchronously between edges while in FAILED.
  - Required: all outputs return to 0 immediately, before the next clk edge.
- SETTLE=0:
  - Stimulus: valid=0 on the first edge after reset release.
  - Required: fail=1, first_cycle=0.
